// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the decode side, the issue stage and the ALU/EX side.
// Pure wiring; it adds no latency.
// Backpressure travels on in_ready and out_ready; the modports fix who drives each wire.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  // decode side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  // ALU/EX side
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd;
  logic            reg_write;
  logic            is_branch;
  logic            branch_ne;
  logic            illegal;

  // Environment view: feeds packets in and sinks issued packets.
  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_control, op_a, op_b, store_data,
           rd, reg_write, is_branch, branch_ne, illegal
  );

  // Issue-stage view.
  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_control, op_a, op_b, store_data,
           rd, reg_write, is_branch, branch_ne, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32 ALU/load/store/branch words into ALU control and operands.
// Latency 1 cycle from input transfer to out_valid; 1 packet/cycle when out_ready stays high.
// Two-entry skid buffer (M + S); in_ready = !S.valid, so it is registered and a stall loses nothing.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [2:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic            branch_ne;
    logic            illegal;
  } pkt_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic            unused_rs1_field;

  pkt_t dec_dat;
  pkt_t m_dat;
  pkt_t s_dat;
  logic m_valid;
  logic s_valid;
  logic in_xfer;
  logic out_xfer;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  // rs1 field selects rs1_data upstream; the value itself arrives already read.
  assign unused_rs1_field = ^bus.instr[19:15];

  // Decode the instruction word into an issue packet; anything unsupported becomes an illegal add.
  always_comb begin
    dec_dat             = '0;
    dec_dat.op_a        = bus.rs1_data;
    dec_dat.op_b        = bus.rs2_data;
    dec_dat.store_data  = bus.rs2_data;
    dec_dat.rd          = bus.instr[11:7];
    dec_dat.alu_control = ALU_ADD;
    case (opcode)
      OPC_R: begin
        dec_dat.reg_write = 1'b1;
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          dec_dat.illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  dec_dat.alu_control = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b111:  dec_dat.alu_control = ALU_AND;
            3'b110:  dec_dat.alu_control = ALU_OR;
            3'b100:  dec_dat.alu_control = ALU_XOR;
            3'b010:  dec_dat.alu_control = ALU_SLT;
            default: dec_dat.illegal     = 1'b1;
          endcase
        end
      end
      OPC_I: begin
        dec_dat.reg_write = 1'b1;
        dec_dat.op_b      = imm_i;
        case (funct3)
          3'b000:  dec_dat.alu_control = ALU_ADD;
          3'b111:  dec_dat.alu_control = ALU_AND;
          3'b110:  dec_dat.alu_control = ALU_OR;
          3'b100:  dec_dat.alu_control = ALU_XOR;
          3'b010:  dec_dat.alu_control = ALU_SLT;
          default: dec_dat.illegal     = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_dat.reg_write = 1'b1;
        dec_dat.op_b      = imm_i;
      end
      OPC_STORE: begin
        dec_dat.op_b = imm_s;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_dat.alu_control = ALU_SUB;
          dec_dat.is_branch   = 1'b1;
          dec_dat.branch_ne   = funct3[0];
        end else begin
          dec_dat.illegal = 1'b1;
        end
      end
      default: dec_dat.illegal = 1'b1;
    endcase
    // Illegal packets still flow in order but must not write back or branch.
    if (dec_dat.illegal) begin
      dec_dat.alu_control = ALU_ADD;
      dec_dat.reg_write   = 1'b0;
      dec_dat.is_branch   = 1'b0;
      dec_dat.branch_ne   = 1'b0;
    end
    if (dec_dat.rd == 5'd0) begin
      dec_dat.reg_write = 1'b0;
    end
  end

  assign in_xfer  = bus.in_valid && !s_valid;
  assign out_xfer = m_valid && bus.out_ready;

  // Skid buffer: M feeds the output, S catches the one packet accepted while M stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_dat   <= '0;
      s_dat   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_xfer) begin
      if (s_valid) begin
        m_dat   <= s_dat;
        m_valid <= 1'b1;
        if (in_xfer) begin
          s_dat <= dec_dat;
        end else begin
          s_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        m_dat   <= dec_dat;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      s_dat   <= dec_dat;
      s_valid <= 1'b1;
    end
  end

  assign bus.in_ready    = !s_valid;
  assign bus.out_valid   = m_valid;
  assign bus.alu_control = m_dat.alu_control;
  assign bus.op_a        = m_dat.op_a;
  assign bus.op_b        = m_dat.op_b;
  assign bus.store_data  = m_dat.store_data;
  assign bus.rd          = m_dat.rd;
  assign bus.reg_write   = m_dat.reg_write;
  assign bus.is_branch   = m_dat.is_branch;
  assign bus.branch_ne   = m_dat.branch_ne;
  assign bus.illegal     = m_dat.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid/backpressure, flush and async reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed from the instruction encodings.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = vld;
    bus.instr    = ins;
    bus.rs1_data = a;
    bus.rs2_data = b;
  endtask

  // Send one packet with out_ready high and check the issued fields one cycle later.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] alu, input logic [31:0] opb, input logic [4:0] rdx,
                       input logic rw, input logic br, input logic bne, input logic ill);
    drive(1'b1, ins, a, b);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk({tag, ".vld"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".alu"}, {29'd0, bus.alu_control}, {29'd0, alu});
    chk({tag, ".opa"}, bus.op_a, a);
    chk({tag, ".opb"}, bus.op_b, opb);
    chk({tag, ".sd"}, bus.store_data, b);
    chk({tag, ".rd"}, {27'd0, bus.rd}, {27'd0, rdx});
    chk({tag, ".ctl"}, {28'd0, bus.reg_write, bus.is_branch, bus.branch_ne, bus.illegal},
        {28'd0, rw, br, bne, ill});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst.op_a", bus.op_a, 32'd0);
    rst_n = 1'b1;
    tick();

    //      tag     instr         rs1           rs2          alu    op_b          rd     rw br ne il
    issue("add",  32'h002081B3, 32'd5,        32'd7,        3'b000, 32'd7,        5'd3,  1, 0, 0, 0);
    issue("addi", 32'hFFF00093, 32'd0,        32'd9,        3'b000, 32'hFFFFFFFF, 5'd1,  1, 0, 0, 0);
    issue("sw",   32'hFE20AE23, 32'h1000,     32'hCAFEF00D, 3'b000, 32'hFFFFFFFC, 5'd28, 0, 0, 0, 0);
    issue("bne",  32'h00209463, 32'd4,        32'd4,        3'b001, 32'd4,        5'd8,  0, 1, 1, 0);
    issue("sll",  32'h002091B3, 32'd1,        32'd2,        3'b000, 32'd2,        5'd3,  0, 0, 0, 1);
    issue("sub",  32'h402081B3, 32'd10,       32'd3,        3'b001, 32'd3,        5'd3,  1, 0, 0, 0);
    issue("and",  32'h0020F1B3, 32'hF0,       32'h3C,       3'b010, 32'h3C,       5'd3,  1, 0, 0, 0);
    issue("slti", 32'h0050A193, 32'd2,        32'd0,        3'b101, 32'd5,        5'd3,  1, 0, 0, 0);
    issue("lw",   32'h0080A183, 32'h200,      32'd1,        3'b000, 32'd8,        5'd3,  1, 0, 0, 0);
    issue("addx0",32'h00208033, 32'd1,        32'd1,        3'b000, 32'd1,        5'd0,  0, 0, 0, 0);
    issue("beq",  32'h00208063, 32'd6,        32'd7,        3'b001, 32'd7,        5'd0,  0, 1, 0, 0);
    issue("blt",  32'h0020C063, 32'd6,        32'd7,        3'b000, 32'd7,        5'd0,  0, 0, 0, 1);
    tick();
    chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: P0 parks in M, P1 in S, P2 waits upstream.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h100, 32'd0);
    tick();
    chk("skid.p0_vld", {31'd0, bus.out_valid}, 32'd1);
    chk("skid.p0_rdy", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'h002081B3, 32'h101, 32'd0);
    tick();
    chk("skid.full_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("skid.hold_p0", bus.op_a, 32'h100);
    drive(1'b1, 32'h002081B3, 32'h102, 32'd0);
    tick();
    chk("skid.still_full", {31'd0, bus.in_ready}, 32'd0);
    chk("skid.stable_p0", bus.op_a, 32'h100);
    bus.out_ready = 1'b1;
    tick();
    chk("skid.out_p1", bus.op_a, 32'h101);
    chk("skid.rdy_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("skid.out_p2", bus.op_a, 32'h102);
    chk("skid.p2_vld", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("skid.drained", {31'd0, bus.out_valid}, 32'd0);

    // Flush with both entries full and a packet on the input.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h200, 32'd0);
    tick();
    drive(1'b1, 32'h002081B3, 32'h201, 32'd0);
    tick();
    chk("flush.pre_full", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 32'h002081B3, 32'h202, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush.in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("flush.dropped", {31'd0, bus.out_valid}, 32'd0);

    // Async reset mid-stream with a stalled packet.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0020F1B3, 32'h55, 32'h66);
    tick();
    drive(1'b1, 32'h002081B3, 32'h77, 32'h88);
    chk("arst.pre_vld", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst.alu", {29'd0, bus.alu_control}, 32'd0);
    chk("arst.op_a", bus.op_a, 32'd0);
    chk("arst.op_b", bus.op_b, 32'd0);
    chk("arst.sd", bus.store_data, 32'd0);
    chk("arst.ctl", {26'd0, bus.rd, bus.reg_write}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst.post_vld", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that sits directly upstream of the 32-bit single-cycle ALU.
- Accepts a decoded-stage packet: instruction word plus rs1/rs2 register values.
- Generates the ALU's 3-bit control code and the A/B operands, including immediates.
- Registers the result into a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU/EX side can stall without losing instructions.

Parameters:
- XLEN, 32, datapath width of operands (the ALU is fixed at 32; other values are unsupported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  upstream packet valid
- in_ready  output  1  stage can accept a packet
- instr  input  32  RV32 instruction word
- rs1_data  input  XLEN  register-file read port 1
- rs2_data  input  XLEN  register-file read port 2
- out_valid  output  1  issued packet valid
- out_ready  input  1  ALU/EX side accepts the packet
- alu_control  output  3  ALU operation code
- op_a  output  XLEN  ALU operand A
- op_b  output  XLEN  ALU operand B
- store_data  output  XLEN  rs2_data, carried for stores
- rd  output  5  destination register
- reg_write  output  1  writeback enable
- is_branch  output  1  branch; EX evaluates the ALU Zero flag
- branch_ne  output  1  1 = bne (taken on !Zero), 0 = beq
- illegal  output  1  unsupported encoding

Behaviour:
- ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- Decode, with op_a = rs1_data in all cases:
  - 0110011 R-type: funct3 000 gives add (funct7[5]=0) or sub (funct7[5]=1); 111 and; 110 or; 100 xor; 010 slt. op_b = rs2_data, reg_write = 1.
  - 0010011 I-type: funct3 000/111/110/100/010 map to add/and/or/xor/slt. op_b = sign-extended instr[31:20], reg_write = 1.
  - 0000011 load: add, op_b = I-immediate, reg_write = 1.
  - 0100011 store: add, op_b = sign-extended {instr[31:25], instr[11:7]}, reg_write = 0.
  - 1100011 branch: funct3 000 (beq) or 001 (bne) gives sub, op_b = rs2_data, is_branch = 1, branch_ne = funct3[0], reg_write = 0.
- Any other opcode or funct3 (shifts, sltu, other branches, funct7 other than 0000000/0100000 on R-type):
  - illegal = 1, alu_control = 000, reg_write = 0, is_branch = 0.
  - The packet is still issued in order.
- rd = instr[11:7]. If rd == 0, reg_write is forced to 0.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Output fields are held stable while out_valid && !out_ready.
- Buffer: main output register M plus skid register S.
  - in_ready is registered and equals !S.valid.
  - On input transfer: if M is empty or M is transferring this cycle, the packet goes to M (or to M after S moves up); otherwise it goes to S.
  - When M transfers and S is valid, S moves to M in the same cycle and S empties.
  - If an input also arrives that cycle, it lands in S.
  - Strict FIFO order is preserved.
- Latency: 1 cycle from input transfer to out_valid when the buffer is empty. Throughput is 1 packet/cycle with out_ready held high.
- Full: with M and S both valid, in_ready = 0. in_ready returns to 1 the cycle after M drains.
- flush:
  - M.valid and S.valid clear next edge; in_ready = 1 next cycle.
  - A packet offered in the flush cycle is dropped.
  - flush overrides simultaneous input or output transfers; the output transfer in that cycle still counts downstream.
- Reset (async assert, sync release is not required):
  - out_valid = 0, in_ready = 1.
  - All data outputs = 0: alu_control 000, op_a, op_b, store_data, rd, reg_write, is_branch, branch_ne, illegal all 0.
  - Reset mid-stream discards all buffered packets.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, out_ready = 1 -> next cycle out_valid = 1, alu_control 000, op_a 5, op_b 7, rd 3, reg_write 1.
- addi x1,x0,-1 (0xFFF00093) -> op_b 0xFFFFFFFF, alu_control 000. sw x2,-4(x1) (0xFE20AE23) -> op_b 0xFFFFFFFC, reg_write 0, store_data = rs2.
- bne x1,x2 (0x00209463) -> alu_control 001, is_branch 1, branch_ne 1. sll (0x002091B3) -> illegal 1, reg_write 0.
- out_ready = 0, send 3 back-to-back packets P0..P2 -> P0 in M, P1 in S, in_ready = 0, P2 held upstream. Raise out_ready -> P0, P1, P2 emerge in order on consecutive cycles.
- With M and S full, assert flush while in_valid = 1 -> next cycle out_valid 0, in_ready 1, no packet emitted.
- Assert rst_n = 0 mid-stream with out_ready = 0 -> out_valid drops immediately (asynchronously), all outputs 0, in_ready 1 after release.
